// File: rtl/nd_mem_loader.sv
// Write-side loader for the tridiagonal off-diagonal (ND) memory: packs a serial
// element stream into {upper, lower} row words and issues one write per row.
module nd_mem_loader #(
  parameter int NO_OF_NON_DIAGONALS = 2,
  parameter int A_MEM_HEIGHT        = 64,
  parameter int ELEMENT_WIDTH       = 32,
  parameter int ADDR_WIDTH          = 6
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic [ADDR_WIDTH:0]                           num_rows,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [ELEMENT_WIDTH-1:0]                      in_data,
  output logic                                          wr_en,
  output logic [ADDR_WIDTH-1:0]                         wr_addr,
  output logic [ELEMENT_WIDTH*NO_OF_NON_DIAGONALS-1:0]  wr_data,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          error
);

  localparam logic [ADDR_WIDTH:0] MIN_ROWS = (ADDR_WIDTH+1)'(2);
  localparam logic [ADDR_WIDTH:0] MAX_ROWS = (ADDR_WIDTH+1)'(A_MEM_HEIGHT);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                     state, state_nxt;
  logic [ADDR_WIDTH-1:0]      row;
  logic [ADDR_WIDTH-1:0]      last_row;
  logic                       lower_filled;
  logic [ELEMENT_WIDTH-1:0]   lower;
  logic [ELEMENT_WIDTH-1:0]   upper;
  logic                       start_ok;
  logic                       accept;
  logic                       row_is_last;
  logic                       row_complete;

  assign start_ok     = start && (num_rows >= MIN_ROWS) && (num_rows <= MAX_ROWS);
  assign accept       = in_valid && (state == COLLECT);
  assign row_is_last  = (row == last_row);
  // First and last rows carry a single element; interior rows need two.
  assign row_complete = (row == '0) || row_is_last || lower_filled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = COLLECT;
      end
      COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && row_complete) state_nxt = WRITE;
      end
      WRITE: begin
        wr_en     = 1'b1;
        busy      = 1'b1;
        wr_addr   = row;
        wr_data   = {upper, lower};
        state_nxt = row_is_last ? DONE : COLLECT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row          <= '0;
      last_row     <= '0;
      lower_filled <= 1'b0;
      lower        <= '0;
      upper        <= '0;
      error        <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            last_row     <= ADDR_WIDTH'(num_rows - 1'b1);
            row          <= '0;
            lower_filled <= 1'b0;
            lower        <= '0;
            upper        <= '0;
          end else if (start) begin
            error <= 1'b1;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (row == '0) begin
              upper <= in_data;
            end else if (row_is_last) begin
              lower <= in_data;
            end else if (!lower_filled) begin
              lower        <= in_data;
              lower_filled <= 1'b1;
            end else begin
              upper <= in_data;
            end
          end
        end
        WRITE: begin
          // Clear the row word so padded slots of the next row read as zero.
          if (!row_is_last) begin
            row          <= row + 1'b1;
            lower_filled <= 1'b0;
            lower        <= '0;
            upper        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nd_mem_loader.sv
// Directed bench for nd_mem_loader: table of load/error vectors plus hand-written
// sequences for explicit streams, mid-load start and asynchronous abort.
module tb_nd_mem_loader;
  localparam int AW = 6;
  localparam int EW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_rows = '0;
  logic          in_valid = 1'b0;
  logic [EW-1:0] in_data = '0;
  logic          in_ready, wr_en, busy, done, error;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always #5 clk = ~clk;

  nd_mem_loader #(
    .NO_OF_NON_DIAGONALS(2), .A_MEM_HEIGHT(64), .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  int checks = 0;
  int failures = 0;

  // Monitor: only this process writes these, the main process takes snapshots.
  logic [AW-1:0] waddr_q[$];
  logic [DW-1:0] wdata_q[$];
  int acc_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        waddr_q.push_back(wr_addr);
        wdata_q.push_back(wr_data);
      end
      if (in_valid && in_ready) acc_cnt = acc_cnt + 1;
      if (done) done_cnt = done_cnt + 1;
      if (error) err_cnt = err_cnt + 1;
    end
  end

  logic [EW-1:0] stim[128];

  typedef struct {
    logic [AW:0] n;
    bit          bad;
    bit          toggle;
  } vec_t;
  vec_t vecs[7];

  int wbase, abase, dbase, ebase;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fill_stim(input int seed);
    for (int i = 0; i < 128; i++) stim[i] = (EW'(seed) << 24) | EW'(32'h0005_0000 + i * 3);
  endtask

  function automatic logic [DW-1:0] exp_word(input int r, input int n);
    if (r == 0) return {stim[0], 32'h0};
    if (r == n - 1) return {32'h0, stim[2 * n - 3]};
    return {stim[2 * r], stim[2 * r - 1]};
  endfunction

  task automatic snapshot();
    wbase = waddr_q.size();
    abase = acc_cnt;
    dbase = done_cnt;
    ebase = err_cnt;
  endtask

  task automatic pulse_start(input logic [AW:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    num_rows = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int total, input bit toggle);
    int idx;
    int cyc;
    bit hs;
    idx = 0;
    cyc = 0;
    in_data = stim[0];
    in_valid = (total > 0);
    while (idx < total && cyc < 1000) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
      if (idx < total) begin
        in_data = stim[idx];
        in_valid = toggle ? ~in_valid : 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (idx < total) chk("feed_timeout", 64'(idx), 64'(total));
  endtask

  task automatic wait_done();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (done_cnt > dbase) break;
    end
    @(negedge clk); #1;
    chk("done_pulses", 64'(done_cnt - dbase), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic check_writes(input int n);
    chk("wr_count", 64'(waddr_q.size() - wbase), 64'(n));
    chk("accepts", 64'(acc_cnt - abase), 64'(2 * n - 2));
    for (int i = 0; i < n; i++) begin
      if (wbase + i < waddr_q.size()) begin
        chk("wr_addr", 64'(waddr_q[wbase + i]), 64'(i));
        chk("wr_data", wdata_q[wbase + i], exp_word(i, n));
      end
    end
  endtask

  task automatic run_load(input int n, input bit toggle);
    snapshot();
    pulse_start((AW+1)'(n));
    feed(2 * n - 2, toggle);
    wait_done();
    check_writes(n);
    chk("no_error_on_load", 64'(err_cnt - ebase), 64'd0);
  endtask

  initial begin
    vecs[0] = '{7'd1,   1'b1, 1'b0};
    vecs[1] = '{7'd0,   1'b1, 1'b0};
    vecs[2] = '{7'd65,  1'b1, 1'b0};
    vecs[3] = '{7'd2,   1'b0, 1'b0};
    vecs[4] = '{7'd5,   1'b0, 1'b1};
    vecs[5] = '{7'd64,  1'b0, 1'b1};
    vecs[6] = '{7'd127, 1'b1, 1'b0};

    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      fill_stim(v + 1);
      if (vecs[v].bad) begin
        snapshot();
        pulse_start(vecs[v].n);
        @(negedge clk);
        chk("error_pulse", 64'(error), 64'd1);
        chk("busy_on_error", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        chk("error_count", 64'(err_cnt - ebase), 64'd1);
        chk("no_wr_on_error", 64'(waddr_q.size() - wbase), 64'd0);
        chk("idle_after_error", 64'(in_ready), 64'd0);
      end else begin
        run_load(int'(vecs[v].n), vecs[v].toggle);
      end
    end

    // Explicit N=3 stream A,B,C,D.
    stim[0] = 32'hAAAA_0001; stim[1] = 32'hBBBB_0002;
    stim[2] = 32'hCCCC_0003; stim[3] = 32'hDDDD_0004;
    snapshot();
    pulse_start(7'd3);
    feed(4, 1'b0);
    wait_done();
    chk("n3_count", 64'(waddr_q.size() - wbase), 64'd3);
    chk("n3_accepts", 64'(acc_cnt - abase), 64'd4);
    if (waddr_q.size() - wbase == 3) begin
      chk("n3_row0", wdata_q[wbase],     64'hAAAA_0001_0000_0000);
      chk("n3_row1", wdata_q[wbase + 1], 64'hCCCC_0003_BBBB_0002);
      chk("n3_row2", wdata_q[wbase + 2], 64'h0000_0000_DDDD_0004);
      chk("n3_addr2", 64'(waddr_q[wbase + 2]), 64'd2);
    end

    // Explicit N=2 stream 11,22.
    stim[0] = 32'd11; stim[1] = 32'd22;
    snapshot();
    pulse_start(7'd2);
    feed(2, 1'b0);
    wait_done();
    chk("n2_count", 64'(waddr_q.size() - wbase), 64'd2);
    if (waddr_q.size() - wbase == 2) begin
      chk("n2_row0", wdata_q[wbase],     {32'd11, 32'd0});
      chk("n2_row1", wdata_q[wbase + 1], {32'd0, 32'd22});
    end

    // start re-pulsed mid-load must be ignored.
    fill_stim(9);
    snapshot();
    pulse_start(7'd4);
    fork
      feed(6, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        num_rows = 7'd5;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done();
    check_writes(4);
    chk("midstart_no_error", 64'(err_cnt - ebase), 64'd0);

    // Asynchronous abort during row 2 of N=8, then a fresh load.
    fill_stim(10);
    snapshot();
    pulse_start(7'd8);
    feed(4, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_wr_en", 64'(wr_en), 64'd0);
    chk("abort_wr_data", wr_data, 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_rows_written", 64'(waddr_q.size() - wbase), 64'd2);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fill_stim(11);
    run_load(8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
